// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration in mem_port_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        DATA  = 1'b0,
        FETCH = 1'b1
    } src_t;

    localparam int MEM_LAT_DEF = 2;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_arb_lat_counter.sv
// Latency counter: loads a start value, counts down to zero and holds there.
// Build option: none (MEM_ARB_RR_EN only affects mem_port_arbiter).
module mem_arb_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and the memory stage.
// Build option: define MEM_ARB_RR_EN for round-robin; otherwise data beats fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output state_t            state
);

    logic             data_req;
    logic             accept;
    logic             pick_data;
    src_t             src;
    logic             we_l;
    logic [CNT_W-1:0] count;
    logic             cnt_zero;

    assign data_req  = mem_rd | mem_wr;
    assign accept    = (state == IDLE) & (data_req | if_req);
    assign if_stall  = if_req & ~if_done;
    assign mem_stall = data_req & ~mem_done;

`ifdef MEM_ARB_RR_EN
    src_t last_grant;

    // Under contention the source that was not served last goes first.
    assign pick_data = data_req & (~if_req | (last_grant == FETCH));

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= FETCH;
        end else if (accept) begin
            last_grant <= pick_data ? DATA : FETCH;
        end
    end
`else
    // The memory stage holds the older instruction, so it always wins.
    assign pick_data = data_req;
`endif

    mem_arb_lat_counter u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .dec      (state == BUSY),
        .load_val (CNT_W'(MEM_LAT)),
        .count    (count),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src       <= FETCH;
            we_l      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= BUSY;
                        ram_en <= 1'b1;
                        if (pick_data) begin
                            src       <= DATA;
                            we_l      <= mem_wr;
                            ram_we    <= mem_wr;
                            ram_addr  <= mem_addr;
                            ram_wdata <= mem_wdata;
                        end else begin
                            src      <= FETCH;
                            we_l     <= 1'b0;
                            ram_addr <= if_addr;
                        end
                    end
                end
                BUSY: begin
                    // Count reaches zero exactly when ram_rdata is valid.
                    if (cnt_zero) begin
                        state <= RESP;
                        if (src == DATA) begin
                            mem_done <= 1'b1;
                            if (!we_l) begin
                                mem_rdata <= ram_rdata;
                            end
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= ram_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the processor's single-port unified 16-bit memory between the instruction-fetch stage and the memory stage.
- The memory stage issues loads and stores: address from ALU result, write data from the third register argument.
- Accepts one access at a time and drives the RAM port from registers.
- Returns read data with a one-cycle done pulse, and generates the stall that freezes the requesting stage until its access completes.

## Interface
- DATA_W, 16, data and address width
- MEM_LAT, 2, RAM read latency in cycles from the `ram_en` cycle to valid `ram_rdata`; legal range 1..15
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until `if_done`
- if_addr  in  DATA_W  fetch address
- if_done  out  1  one-cycle pulse, fetch data valid on `if_rdata`
- if_rdata  out  DATA_W  fetched word, holds until next fetch capture
- if_stall  out  1  `if_req & ~if_done`, combinational
- mem_rd  in  1  load request (MemRead), held until `mem_done`
- mem_wr  in  1  store request (MemWrite), held until `mem_done`
- mem_addr  in  DATA_W  access address
- mem_wdata  in  DATA_W  store data
- mem_done  out  1  one-cycle completion pulse
- mem_rdata  out  DATA_W  load data, holds until next load capture
- mem_stall  out  1  `(mem_rd|mem_wr) & ~mem_done`, combinational
- ram_en  out  1  RAM access strobe, registered
- ram_we  out  1  RAM write enable, registered, only high with `ram_en`
- ram_addr  out  DATA_W  registered RAM address
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data

## Operation
- FSM states:
  - IDLE: samples requests.
    - Data request present: latch address, wdata and we (`we = mem_wr`); source = DATA; go to BUSY.
    - Otherwise, fetch request present: latch `if_addr`, we = 0; source = FETCH; go to BUSY.
    - Otherwise: stay in IDLE.
  - On every IDLE→BUSY transition the latency counter loads MEM_LAT.
  - BUSY: `ram_en` (and `ram_we` if a store) is high only in the first BUSY cycle.
    - While count > 0: decrement count each edge.
    - When count = 0: capture `ram_rdata` into the source's rdata register (loads and fetches only), then go to RESP.
  - RESP: `mem_done` or `if_done` (per source) is high for this single cycle; requests are ignored; go to IDLE.
- Arbitration: data beats fetch by default, because the memory stage holds the older instruction.
- Request handling rules:
  - `mem_rd` and `mem_wr` both high → treated as a store; `mem_rdata` unchanged.
  - A store never modifies `mem_rdata`; a load never modifies `if_rdata`, and vice versa.
  - Input changes during BUSY/RESP are ignored; the latched values are used.
- Counter width: 4 bits; the MEM_LAT range above guarantees no wrap.

## Timing
- Request sampled at edge E:
  - `ram_en` high during the cycle after E.
  - `ram_rdata` captured at edge E+1+MEM_LAT.
  - done high during the cycle after E+1+MEM_LAT.
  - IDLE again at edge E+2+MEM_LAT.
  - Earliest next acceptance at edge E+3+MEM_LAT.
- Throughput: one access per MEM_LAT+3 cycles.
- Reset values:
  - state IDLE, count 0.
  - `ram_en`, `ram_we`, `if_done`, `mem_done` = 0.
  - `ram_addr`, `ram_wdata`, `if_rdata`, `mem_rdata` = 0.
  - Last-grant = FETCH.
- Reset mid-operation: any in-flight access is abandoned and no done pulse is produced. The stalls reflect raw requests (done = 0).
- Requesters must hold the request through the done cycle and may change it after. Because RESP ignores requests, the held request is never issued twice.

## Configuration
- MEM_ARB_RR_EN:
  - Defined: round-robin. When both request in IDLE, the source not granted last wins. Last-grant is updated on each IDLE→BUSY transition.
  - Undefined: fixed data-over-fetch priority; the last-grant register is not built.
- Single-requester behaviour is identical in both modes.

## Structure
- `mem_arb_pkg`:
  - State enum: IDLE, BUSY, RESP.
  - Source enum: DATA, FETCH.
  - Default MEM_LAT and the counter width constant.
- Sub-module `mem_arb_lat_counter`: a load/decrement/zero-flag counter.

## Test plan
- Reset, then release with all requests low → all outputs 0, state IDLE, no `ram_en` for 10 cycles.
- Load, MEM_LAT=2: `mem_rd`=1, `mem_addr`=0x0004, RAM returns 0xAAAA → `ram_en` one cycle at addr 0x0004, `ram_we`=0; `mem_done` pulse 4 cycles after sampling; `mem_rdata`=0xAAAA; `mem_stall` high until done.
- Store: `mem_wr`=1, addr 0x0010, wdata 0x1234 → `ram_en`=`ram_we`=1 for one cycle with those values; `mem_done` pulses; `mem_rdata` unchanged.
- Contention: `if_req`=1 (addr 0x0000) and `mem_rd`=1 (addr 0x0004) held together:
  - Without MEM_ARB_RR_EN: data completes first, then fetch; `if_stall` high throughout.
  - With MEM_ARB_RR_EN after a prior data grant: fetch first.
- Reset asserted the cycle after `ram_en` of a load → no `mem_done`, `mem_rdata`=0, state IDLE.
- Both `mem_rd` and `mem_wr` high → store issued, `ram_we`=1, `mem_rdata` unchanged.
